ddr3_pll_sequencer: RTL and testbench
=====================================

// Module: ddr3_pll_sequencer
// PURPOSE
//  Power-up/recovery sequencer for the DDR3 PLL. It pulses PLL reset, waits for a stable
//  synchronized lock, then enables CLKOUT0 and CLKOUT2 in order and flags ready to the DDR3 IP.
//  Sits beside the DDR3 PLL in the clock/reset tree, clocked by the same 50 MHz board clock.
//  Supervises lock at runtime; retries on timeout or lock loss; latches fail after MAX_RETRIES.
// PARAMETERS
//  RST_CYCLES     16    PLL reset pulse width, clkin cycles (>=1)
//  LOCK_TIMEOUT   4096  max cycles in WAIT_LOCK before a retry
//  STABLE_CYCLES  256   consecutive synced-lock cycles required before enabling clocks
//  ENABLE_GAP     8     cycles between enclk0 rise and enclk2 rise
//  MAX_RETRIES    3     failed attempts tolerated before FAIL (counter width 4 bits)
// PORTS
//  clkin        in   1  board clock, 50 MHz; all logic on rising edge
//  reset        in   1  synchronous, active-high
//  restart      in   1  1-cycle pulse: re-run full sequence from RESET_PLL (also clears FAIL)
//  lock         in   1  PLL lock, asynchronous to clkin
//  pll_reset    out  1  to PLL RESET
//  enclk0       out  1  to PLL ENCLK0
//  enclk2       out  1  to PLL ENCLK2
//  ready        out  1  both clocks enabled and lock stable
//  fail         out  1  sticky: retries exhausted
//  retry_cnt    out  4  attempts failed since reset/restart, saturates at 15
//  state        out  3  current FSM state encoding (debug)
// BEHAVIOUR
//  Reset values: pll_reset=1, enclk0=0, enclk2=0, ready=0, fail=0, retry_cnt=0, state=RESET_PLL.
//  lock passes a 2-flop synchronizer -> lock_s (2-cycle latency); FSM uses lock_s only.
//  One shared cycle counter cnt, cleared on every state entry.
//  States (encoding):
//   RESET_PLL(0): pll_reset=1, enables 0. After RST_CYCLES cycles -> WAIT_LOCK.
//   WAIT_LOCK(1): pll_reset=0. lock_s=1 -> STABLE. cnt reaches LOCK_TIMEOUT-1 with lock_s=0 -> RETRY.
//   STABLE(2):    lock_s=0 -> RETRY. STABLE_CYCLES consecutive lock_s=1 -> EN0.
//   EN0(3):       enclk0=1. After ENABLE_GAP cycles -> EN2. lock_s=0 -> RETRY.
//   EN2(4):       enclk2=1 (enclk0 held). Next cycle -> RUN.
//   RUN(5):       ready=1. lock_s=0 -> RETRY (ready, enclk0, enclk2 drop same edge as transition).
//   RETRY(6):     single cycle; enables 0, ready 0, retry_cnt+1 (sat). If new count > MAX_RETRIES
//                 -> FAIL else -> RESET_PLL.
//   FAIL(7):      pll_reset=1, enables 0, ready 0, fail=1; leaves only on restart or reset.
//  Outputs registered (Moore); enclk0/enclk2/ready deassert no later than 1 cycle after lock_s falls.
//  Enable order invariant: enclk2=1 implies enclk0=1; ready=1 implies both enables=1.
//  restart (any state): next state RESET_PLL, retry_cnt=0, fail=0, enables/ready 0.
//  restart and lock_s fall same cycle: restart wins, no retry_cnt increment.
//  reset overrides restart. Mid-sequence reset returns all outputs to reset values next edge.
//  Lock glitch inside STABLE restarts via RETRY (not in-place count reset) so it is counted.
//  Successful reach of RUN does not clear retry_cnt; only reset/restart clear it.
// TESTING
//  1 lock rises 100 cycles after pll_reset falls, stays high -> enclk0 at STABLE+256, enclk2 8 later,
//    ready 1 cycle after; retry_cnt=0, pll_reset width exactly 16.
//  2 lock never rises -> 4 RETRY passes, retry_cnt=4, fail=1, pll_reset held 1, enables 0.
//  3 In RUN drop lock 1 cycle -> enables/ready low within 3 cycles of lock fall, retry_cnt=1,
//    new 16-cycle pll_reset pulse, sequence completes again.
//  4 lock glitch low 1 cycle at STABLE cnt=200 -> RETRY, no enable asserted, retry_cnt=1.
//  5 In FAIL pulse restart -> fail=0, retry_cnt=0, sequence runs to ready with good lock.
//  6 restart coincident with lock_s fall in RUN -> RESET_PLL, retry_cnt stays 0; reset asserted
//    in EN0 -> next edge pll_reset=1, enclk0=0.

Source files
------------

// File: rtl/ddr3_pll_sequencer.sv
// DDR3 PLL power-up/recovery sequencer: pulses PLL reset, qualifies a synchronized lock,
// enables CLKOUT0 then CLKOUT2, flags ready, and retries or latches fail on lock trouble.
module ddr3_pll_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned ENABLE_GAP    = 8,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       restart,
  input  logic       lock,
  output logic       pll_reset,
  output logic       enclk0,
  output logic       enclk2,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  localparam int unsigned MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_B   = (STABLE_CYCLES > ENABLE_GAP) ? STABLE_CYCLES : ENABLE_GAP;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(ENABLE_GAP - 1);
  localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_EN0       = 3'd3,
    S_EN2       = 3'd4,
    S_RUN       = 3'd5,
    S_RETRY     = 3'd6,
    S_FAIL      = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_cnt_q, retry_cnt_d;
  logic          lock_meta_q, lock_meta_d;
  logic          lock_s_q, lock_s_d;
  logic          pll_reset_q, pll_reset_d;
  logic          enclk0_q, enclk0_d;
  logic          enclk2_q, enclk2_d;
  logic          ready_q, ready_d;
  logic          fail_q, fail_d;

  always_comb begin
    lock_meta_d = lock;
    lock_s_d    = lock_meta_q;
    state_d     = state_q;
    retry_cnt_d = retry_cnt_q;

    unique case (state_q)
      S_RESET_PLL: if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (lock_s_q)                    state_d = S_STABLE;
        else if (cnt_q == TIMEOUT_LAST)  state_d = S_RETRY;
      end
      S_STABLE: begin
        if (!lock_s_q)                   state_d = S_RETRY;
        else if (cnt_q == STABLE_LAST)   state_d = S_EN0;
      end
      S_EN0: begin
        if (!lock_s_q)                   state_d = S_RETRY;
        else if (cnt_q == GAP_LAST)      state_d = S_EN2;
      end
      // Lock loss in EN2 is honoured here so enables never lag a lock fall by more than a cycle.
      S_EN2:   state_d = lock_s_q ? S_RUN : S_RETRY;
      S_RUN:   if (!lock_s_q) state_d = S_RETRY;
      S_RETRY: state_d = (retry_cnt_q > RETRY_LIMIT) ? S_FAIL : S_RESET_PLL;
      S_FAIL:  state_d = S_FAIL;
    endcase

    // Count is bumped on entry to RETRY so the RETRY cycle itself decides on the new value.
    if (state_d == S_RETRY && state_q != S_RETRY && retry_cnt_q != 4'hF)
      retry_cnt_d = retry_cnt_q + 4'd1;

    if (restart) begin
      state_d     = S_RESET_PLL;
      retry_cnt_d = '0;
    end

    cnt_d = (state_d != state_q || restart) ? '0 : cnt_q + 1'b1;

    pll_reset_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
    enclk0_d    = (state_d == S_EN0) || (state_d == S_EN2) || (state_d == S_RUN);
    enclk2_d    = (state_d == S_EN2) || (state_d == S_RUN);
    ready_d     = (state_d == S_RUN);
    fail_d      = (state_d == S_FAIL);
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      retry_cnt_q <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      pll_reset_q <= 1'b1;
      enclk0_q    <= 1'b0;
      enclk2_q    <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_cnt_q <= retry_cnt_d;
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
      pll_reset_q <= pll_reset_d;
      enclk0_q    <= enclk0_d;
      enclk2_q    <= enclk2_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign enclk0    = enclk0_q;
  assign enclk2    = enclk2_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_ddr3_pll_sequencer.sv
// Directed bench for ddr3_pll_sequencer with default parameters and hand-computed cycle counts.
module tb_ddr3_pll_sequencer;

  logic       clkin = 1'b0;
  logic       reset, restart, lock;
  logic       pll_reset, enclk0, enclk2, ready, fail;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  int unsigned errors = 0;
  int unsigned checks = 0;

  ddr3_pll_sequencer #(
    .RST_CYCLES(16), .LOCK_TIMEOUT(4096), .STABLE_CYCLES(256),
    .ENABLE_GAP(8), .MAX_RETRIES(3)
  ) dut (
    .clkin(clkin), .reset(reset), .restart(restart), .lock(lock),
    .pll_reset(pll_reset), .enclk0(enclk0), .enclk2(enclk2), .ready(ready),
    .fail(fail), .retry_cnt(retry_cnt), .state(state)
  );

  always #10 clkin = ~clkin;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  // Ticks until state==s (bounded) and checks the number of edges taken.
  task automatic wait_state(input logic [2:0] s, input int exp, input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (state !== s && n < exp + 50);
    if (state !== s) n = -1;
    check_eq(tag, n, exp);
  endtask

  task automatic run_to_ready(input string tag);
    wait_state(3'd3, 256, {tag, "_stable_len"});
    check_eq({tag, "_en0"}, int'(enclk0), 1);
    check_eq({tag, "_en2_early"}, int'(enclk2), 0);
    wait_state(3'd4, 8, {tag, "_gap"});
    check_eq({tag, "_en2"}, int'(enclk2), 1);
    check_eq({tag, "_en0_held"}, int'(enclk0), 1);
    wait_state(3'd5, 1, {tag, "_run"});
    check_eq({tag, "_ready"}, int'(ready), 1);
  endtask

  initial begin
    reset = 1'b1; restart = 1'b0; lock = 1'b0;
    tick(); tick();
    check_eq("rst_state", int'(state), 0);
    check_eq("rst_pll_reset", int'(pll_reset), 1);
    check_eq("rst_en0", int'(enclk0), 0);
    check_eq("rst_en2", int'(enclk2), 0);
    check_eq("rst_ready", int'(ready), 0);
    check_eq("rst_fail", int'(fail), 0);
    check_eq("rst_retry", int'(retry_cnt), 0);

    // 1: clean power-up, lock 100 cycles after pll_reset falls
    reset = 1'b0;
    wait_state(3'd1, 16, "t1_rst_width");
    check_eq("t1_pll_reset_low", int'(pll_reset), 0);
    repeat (100) tick();
    lock = 1'b1;
    wait_state(3'd2, 3, "t1_sync_latency");
    run_to_ready("t1");
    check_eq("t1_retry", int'(retry_cnt), 0);

    // 3: single-cycle lock drop in RUN
    lock = 1'b0;
    tick();
    lock = 1'b1;
    wait_state(3'd6, 2, "t3_drop_latency");
    check_eq("t3_en0", int'(enclk0), 0);
    check_eq("t3_ready", int'(ready), 0);
    check_eq("t3_retry", int'(retry_cnt), 1);
    wait_state(3'd0, 1, "t3_to_reset");
    check_eq("t3_pll_reset", int'(pll_reset), 1);
    wait_state(3'd1, 16, "t3_rst_width");
    wait_state(3'd2, 1, "t3_relock");
    run_to_ready("t3");
    check_eq("t3_retry_kept", int'(retry_cnt), 1);

    // 4: lock glitch at STABLE cnt=200
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check_eq("t4_restart_state", int'(state), 0);
    check_eq("t4_restart_retry", int'(retry_cnt), 0);
    wait_state(3'd1, 16, "t4_rst_width");
    wait_state(3'd2, 1, "t4_stable");
    repeat (200) tick();
    check_eq("t4_mid_stable", int'(state), 2);
    lock = 1'b0;
    tick();
    lock = 1'b1;
    wait_state(3'd6, 2, "t4_glitch_retry");
    check_eq("t4_en0", int'(enclk0), 0);
    check_eq("t4_retry", int'(retry_cnt), 1);

    // 2: lock never rises -> four timeouts then FAIL
    lock = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wait_state(3'd6, (i == 1) ? 4112 : 4113, "t2_timeout");
      check_eq("t2_retry", int'(retry_cnt), i);
    end
    wait_state(3'd7, 1, "t2_fail_state");
    repeat (20) tick();
    check_eq("t2_fail_state_held", int'(state), 7);
    check_eq("t2_fail", int'(fail), 1);
    check_eq("t2_pll_reset", int'(pll_reset), 1);
    check_eq("t2_en0", int'(enclk0), 0);
    check_eq("t2_en2", int'(enclk2), 0);
    check_eq("t2_retry_final", int'(retry_cnt), 4);

    // 5: restart out of FAIL with good lock
    lock = 1'b1;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check_eq("t5_fail", int'(fail), 0);
    check_eq("t5_retry", int'(retry_cnt), 0);
    check_eq("t5_state", int'(state), 0);
    check_eq("t5_pll_reset", int'(pll_reset), 1);
    wait_state(3'd1, 16, "t5_rst_width");
    wait_state(3'd2, 1, "t5_stable");
    run_to_ready("t5");

    // 6: restart on the same edge the FSM first sees lock_s low
    lock = 1'b0;
    tick(); tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check_eq("t6_state", int'(state), 0);
    check_eq("t6_retry", int'(retry_cnt), 0);
    check_eq("t6_en0", int'(enclk0), 0);
    check_eq("t6_ready", int'(ready), 0);
    lock = 1'b1;
    tick();
    check_eq("t6_state_next", int'(state), 0);
    check_eq("t6_retry_next", int'(retry_cnt), 0);
    wait_state(3'd1, 15, "t6_rst_width");
    wait_state(3'd2, 1, "t6_stable");
    wait_state(3'd3, 256, "t6_en0_reach");
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_eq("t6_reset_pll_reset", int'(pll_reset), 1);
    check_eq("t6_reset_en0", int'(enclk0), 0);
    check_eq("t6_reset_state", int'(state), 0);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
